la_wb_master: RTL and testbench

LA_WB_MASTER -- requirements
Module: la_wb_master

---
 rtl/la_wb_master.sv | 175 +++++++++++++++++
 tb/tb_la_wb_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_wb_master.sv
// Wishbone classic single-transfer initiator driven by a logic-analyzer
// command/response handshake. One transfer outstanding, with a per-transfer
// ack timeout and abort on loss of the project-select enable.
module la_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        active,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned DAT_W = 32;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [DAT_W-1:0] r_rsp_dat;
  logic             r_rsp_err;
  logic             r_cyc;
  logic             r_stb;
  logic             r_we;
  logic [SEL_W-1:0] r_sel;
  logic [DAT_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cmd_ready_nxt;
  logic             w_rsp_valid_nxt;
  logic [DAT_W-1:0] w_rsp_dat_nxt;
  logic             w_rsp_err_nxt;
  logic             w_cyc_nxt;
  logic             w_we_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [DAT_W-1:0] w_adr_nxt;
  logic [DAT_W-1:0] w_dat_nxt;
  logic             w_accept;

  assign w_accept = r_cmd_ready & active & cmd_valid;

  // Next-state and next-output decode; ack takes priority over timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt       = 1'b0;
        w_cmd_ready_nxt = active;
        if (w_accept) begin
          w_state_nxt     = S_BUS;
          w_cnt_nxt       = '0;
          w_cyc_nxt       = 1'b1;
          w_we_nxt        = cmd_we;
          w_sel_nxt       = cmd_sel;
          w_adr_nxt       = cmd_adr;
          w_dat_nxt       = cmd_dat;
          w_cmd_ready_nxt = 1'b0;
        end
      end
      S_BUS: begin
        if (!active) begin
          w_state_nxt = S_IDLE;
          w_cyc_nxt   = 1'b0;
        end else if (wbm_ack_i) begin
          w_state_nxt     = S_RESP;
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
          w_rsp_err_nxt   = 1'b0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt     = S_RESP;
          w_cyc_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (!active || rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b0;
          w_cmd_ready_nxt = active;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cyc_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_la_wb_master.sv
// Self-checking bench for la_wb_master: directed and randomized transfers
// compared against a transaction-level model of latency, timeout and data.
module tb_la_wb_master;

  localparam int unsigned TO_A = 4;
  localparam int unsigned TO_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, active, cmd_valid, cmd_we, rsp_ready;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        ack;

  logic        b_active, b_cmd_valid, b_cmd_we, b_rsp_ready, b_ack;
  logic [3:0]  b_cmd_sel;
  logic [31:0] b_cmd_adr, b_cmd_dat, b_dat_i;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err, b_cyc, b_stb, b_we_o;
  logic [31:0] b_rsp_dat, b_adr_o, b_dat_o;
  logic [3:0]  b_sel_o;

  int checks = 0;
  int errors = 0;

  // Responder for DUT A: acks on BUS cycle index resp_wait (-1 = never)
  int          resp_wait = -1;
  logic [31:0] resp_data = '0;
  logic        resp_ack  = 1'b0;
  logic        force_ack = 1'b0;
  int          ack_cnt   = 0;
  assign ack = resp_ack | force_ack;

  la_wb_master #(.TIMEOUT(TO_A)) u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .active(active),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o),
    .wbm_sel_o(sel_o), .wbm_adr_o(adr_o), .wbm_dat_o(dat_o),
    .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  la_wb_master #(.TIMEOUT(TO_B)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .active(b_active),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(b_cmd_we),
    .cmd_sel(b_cmd_sel), .cmd_adr(b_cmd_adr), .cmd_dat(b_cmd_dat),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_dat(b_rsp_dat),
    .rsp_err(b_rsp_err), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we_o),
    .wbm_sel_o(b_sel_o), .wbm_adr_o(b_adr_o), .wbm_dat_o(b_dat_o),
    .wbm_ack_i(b_ack), .wbm_dat_i(b_dat_i)
  );

  // Responder driven on the falling edge, away from the DUT sampling edge
  always @(negedge clk) begin
    if (cyc && stb) begin
      if (resp_wait >= 0 && ack_cnt == resp_wait) begin
        resp_ack = 1'b1;
        dat_i    = resp_data;
      end else begin
        resp_ack = 1'b0;
        dat_i    = 32'hA5A5_5A5A;
      end
      ack_cnt++;
    end else begin
      resp_ack = 1'b0;
      dat_i    = 32'hA5A5_5A5A;
      ack_cnt  = 0;
    end
  end

  // Reference model: bus cycles, response data and error for one transfer
  function automatic void model(input logic we, input int w, input logic [31:0] rd,
                                input int to, output int bus_n,
                                output logic [31:0] d, output logic e);
    if (w >= 0 && w < to) begin
      bus_n = w + 1;
      e     = 1'b0;
      d     = we ? 32'h0 : rd;
    end else begin
      bus_n = to;
      e     = 1'b1;
      d     = 32'h0;
    end
  endfunction

  // Drives one command on DUT A and measures what the bus and response did
  task automatic run_txn(input logic we, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input int w, input logic [31:0] rd,
                         input int hold, input logic poke,
                         output int bus_n, output int lat, output logic [31:0] rdat,
                         output logic rerr, output logic fields_ok, output logic hold_ok,
                         output logic proto_ok, output logic done);
    int guard;
    resp_wait = w; resp_data = rd;
    cmd_we = we; cmd_sel = s; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1;
    bus_n = 0; lat = 0; rdat = '0; rerr = 1'b0;
    fields_ok = 1'b1; hold_ok = 1'b1; proto_ok = 1'b1; done = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    guard = 0;
    while (!rsp_valid && guard < 64) begin
      if (cyc) begin
        bus_n++;
        if (we_o !== we || sel_o !== s || adr_o !== a || dat_o !== d) fields_ok = 1'b0;
      end
      if (stb && !cyc) proto_ok = 1'b0;
      if (cmd_ready) proto_ok = 1'b0;
      @(negedge clk);
      lat++; guard++;
    end
    if (!rsp_valid) return;
    if (cyc || stb || cmd_ready) proto_ok = 1'b0;
    rdat = rsp_dat; rerr = rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin cmd_valid = 1'b1; cmd_adr = ~a; end
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== rdat || rsp_err !== rerr || cmd_ready || cyc)
        hold_ok = 1'b0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid || !cmd_ready || cyc) proto_ok = 1'b0;
    done = 1'b1;
  endtask

  task automatic test_reset;
    checks++; if ({cmd_ready, rsp_valid, rsp_err, cyc, stb, we_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {cmd_ready, rsp_valid, rsp_err, cyc, stb, we_o}); end
    checks++; if ({sel_o, adr_o, dat_o, rsp_dat} !== 100'b0) begin
      errors++; $display("FAIL reset_data got sel=%h adr=%h dat=%h rsp=%h exp 0", sel_o, adr_o, dat_o, rsp_dat); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write;
    int bn, lt, eb; logic [31:0] rd, ed; logic re, ee, fo, ho, po, dn;
    model(1'b1, 0, 32'h0, TO_A, eb, ed, ee);
    run_txn(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 0, 32'h1111_2222, 0, 1'b0,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn) begin errors++; $display("FAIL write_done got 0 exp 1"); end
    checks++; if (lt !== eb + 1) begin errors++; $display("FAIL write_latency got %0d exp %0d", lt, eb + 1); end
    checks++; if (bn !== eb) begin errors++; $display("FAIL write_bus_cycles got %0d exp %0d", bn, eb); end
    checks++; if (rd !== ed || re !== ee) begin
      errors++; $display("FAIL write_rsp got %h/%b exp %h/%b", rd, re, ed, ee); end
    checks++; if (!fo || !po) begin errors++; $display("FAIL write_bus_fields got %b%b exp 11", fo, po); end
  endtask

  task automatic test_read_wait;
    int bn, lt, eb; logic [31:0] rd, ed; logic re, ee, fo, ho, po, dn;
    model(1'b0, 3, 32'h1234_5678, TO_A, eb, ed, ee);
    run_txn(1'b0, 4'hF, 32'h3000_0000, 32'h0, 3, 32'h1234_5678, 0, 1'b0,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn || bn !== eb) begin errors++; $display("FAIL read_cyc_cycles got %0d exp %0d", bn, eb); end
    checks++; if (rd !== ed || re !== ee) begin
      errors++; $display("FAIL read_rsp got %h/%b exp %h/%b", rd, re, ed, ee); end
    checks++; if (lt !== eb + 1) begin errors++; $display("FAIL read_latency got %0d exp %0d", lt, eb + 1); end
  endtask

  task automatic test_timeout;
    int bn, lt, eb; logic [31:0] rd, ed; logic re, ee, fo, ho, po, dn;
    model(1'b0, -1, 32'h0, TO_A, eb, ed, ee);
    run_txn(1'b0, 4'h3, 32'h3000_0010, 32'h0, -1, 32'h0, 0, 1'b0,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn || bn !== eb) begin errors++; $display("FAIL timeout_cyc_cycles got %0d exp %0d", bn, eb); end
    checks++; if (rd !== ed || re !== ee) begin
      errors++; $display("FAIL timeout_rsp got %h/%b exp %h/%b", rd, re, ed, ee); end
  endtask

  task automatic test_resp_hold;
    int bn, lt, eb; logic [31:0] rd, ed; logic re, ee, fo, ho, po, dn;
    model(1'b0, 1, 32'hCAFE_F00D, TO_A, eb, ed, ee);
    run_txn(1'b0, 4'hC, 32'h3000_0020, 32'h0, 1, 32'hCAFE_F00D, 10, 1'b1,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn || !ho) begin errors++; $display("FAIL resp_hold_stable got %b/%b exp 1/1", dn, ho); end
    checks++; if (rd !== ed || !po) begin errors++; $display("FAIL resp_hold_data got %h exp %h", rd, ed); end
  endtask

  task automatic test_random;
    int bn, lt, eb, w; logic [31:0] rd, ed, a, d, x; logic re, ee, fo, ho, po, dn, we;
    logic [3:0] s;
    for (int i = 0; i < 16; i++) begin
      we = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(1, 15));
      a  = $urandom; d = $urandom; x = $urandom;
      w  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
      model(we, w, x, TO_A, eb, ed, ee);
      run_txn(we, s, a, d, w, x, int'($urandom_range(0, 3)), 1'b0,
              bn, lt, rd, re, fo, ho, po, dn);
      checks++; if (!dn || bn !== eb || lt !== eb + 1) begin
        errors++; $display("FAIL rand%0d timing got bus=%0d lat=%0d exp bus=%0d lat=%0d", i, bn, lt, eb, eb + 1); end
      checks++; if (rd !== ed || re !== ee) begin
        errors++; $display("FAIL rand%0d rsp got %h/%b exp %h/%b", i, rd, re, ed, ee); end
      checks++; if (!fo || !ho || !po) begin
        errors++; $display("FAIL rand%0d protocol got %b%b%b exp 111", i, fo, ho, po); end
    end
  endtask

  task automatic test_ack_idle;
    logic bad = 1'b0;
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cyc || rsp_valid || !cmd_ready) bad = 1'b1;
    end
    force_ack = 1'b0;
    @(negedge clk);
    checks++; if (bad || rsp_valid) begin errors++; $display("FAIL ack_idle got bad=%b rsp=%b exp 0/0", bad, rsp_valid); end
  endtask

  task automatic test_active_abort;
    int bn, lt; logic [31:0] rd; logic re, fo, ho, po, dn, seen;
    resp_wait = -1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0040; cmd_valid = 1'b1;
    for (int g = 0; g < 20 && !cmd_ready; g++) @(negedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL abort_pre_cyc got %b exp 1", cyc); end
    active = 1'b0;
    @(negedge clk);
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin
      errors++; $display("FAIL abort_active_cyc got %b%b exp 00", cyc, stb); end
    seen = rsp_valid;
    repeat (3) begin @(negedge clk); seen |= rsp_valid; end
    checks++; if (seen) begin errors++; $display("FAIL abort_active_rsp got 1 exp 0"); end
    active = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 4'hF, 32'h3000_0044, 32'h0, 0, 32'h0BAD_CAFE, 0, 1'b0,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn || rd !== 32'h0BAD_CAFE || re !== 1'b0) begin
      errors++; $display("FAIL abort_active_next got %h/%b exp 0badcafe/0", rd, re); end
  endtask

  task automatic test_reset_abort;
    int bn, lt; logic [31:0] rd; logic re, fo, ho, po, dn;
    resp_wait = -1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h3000_0050; cmd_dat = 32'h5555_AAAA;
    cmd_valid = 1'b1;
    for (int g = 0; g < 20 && !cmd_ready; g++) @(negedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0 || adr_o !== 32'h0) begin
      errors++; $display("FAIL reset_abort_async got cyc=%b stb=%b adr=%h exp 0", cyc, stb, adr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_abort_after got rsp=%b rdy=%b exp 0/1", rsp_valid, cmd_ready); end
    run_txn(1'b1, 4'h1, 32'h3000_0054, 32'h0000_0077, 2, 32'hFFFF_FFFF, 1, 1'b0,
            bn, lt, rd, re, fo, ho, po, dn);
    checks++; if (!dn || bn !== 3 || rd !== 32'h0 || re !== 1'b0 || !fo) begin
      errors++; $display("FAIL reset_abort_next got bus=%0d rsp=%h/%b exp 3 0/0", bn, rd, re); end
  endtask

  task automatic test_resp_drop;
    resp_wait = 0; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h3000_0060; cmd_valid = 1'b1;
    for (int g = 0; g < 20 && !cmd_ready; g++) @(negedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL resp_drop_pre got %b exp 1", rsp_valid); end
    active = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL resp_drop_discard got %b exp 0", rsp_valid); end
    active = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL resp_drop_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_ack_timeout_tie;
    int eb, n; logic [31:0] ed; logic ee;
    model(1'b0, 1, 32'h7654_3210, TO_B, eb, ed, ee);
    b_cmd_we = 1'b0; b_cmd_sel = 4'hF; b_cmd_adr = 32'h3000_0070; b_cmd_valid = 1'b1;
    for (int g = 0; g < 20 && !b_cmd_ready; g++) @(negedge clk);
    @(negedge clk); b_cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_cyc !== 1'b1) begin errors++; $display("FAIL tie_cyc2 got %b exp 1", b_cyc); end
    b_ack = 1'b1; b_dat_i = 32'h7654_3210;
    @(negedge clk);
    b_ack = 1'b0; b_dat_i = 32'h0;
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== ee || b_rsp_dat !== ed || b_cyc !== 1'b0) begin
      errors++; $display("FAIL tie_rsp got v=%b e=%b d=%h exp 1/%b/%h", b_rsp_valid, b_rsp_err, b_rsp_dat, ee, ed); end
    b_rsp_ready = 1'b1; @(negedge clk); b_rsp_ready = 1'b0;
    model(1'b0, -1, 32'h0, TO_B, eb, ed, ee);
    b_cmd_valid = 1'b1;
    for (int g = 0; g < 20 && !b_cmd_ready; g++) @(negedge clk);
    @(negedge clk); b_cmd_valid = 1'b0;
    n = 0;
    for (int g = 0; g < 40 && !b_rsp_valid; g++) begin
      if (b_cyc) n++;
      @(negedge clk);
    end
    checks++; if (!b_rsp_valid || n !== eb || b_rsp_err !== ee || b_rsp_dat !== ed) begin
      errors++; $display("FAIL b_timeout got v=%b cyc=%0d e=%b d=%h exp 1/%0d/%b/%h", b_rsp_valid, n, b_rsp_err, b_rsp_dat, eb, ee, ed); end
    b_rsp_ready = 1'b1; @(negedge clk); b_rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; active = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; rsp_ready = 1'b0;
    cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    b_active = 1'b1; b_cmd_valid = 1'b0; b_cmd_we = 1'b0; b_rsp_ready = 1'b0; b_ack = 1'b0;
    b_cmd_sel = '0; b_cmd_adr = '0; b_cmd_dat = '0; b_dat_i = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_write;
    test_read_wait;
    test_timeout;
    test_resp_hold;
    test_random;
    test_ack_idle;
    test_active_abort;
    test_reset_abort;
    test_resp_drop;
    test_ack_timeout_tie;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
